// File: rtl/mips_pkg.sv
// Shared MIPS definitions: register-file geometry and the scoreboard's default latency width.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int DEF_LAT_W  = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_reg_counter.sv
// Countdown for one register's pending write; busy while the count is nonzero.
module sb_reg_counter
   import mips_pkg::*;
#(
   parameter int LAT_W = DEF_LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic             busy
);

   logic [LAT_W-1:0] r_cnt;

   // Flush beats a new reservation, which beats the normal countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {LAT_W{1'b0}};
      end else if (flush) begin
         r_cnt <= {LAT_W{1'b0}};
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != {LAT_W{1'b0}}) begin
         r_cnt <= r_cnt - {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= {LAT_W{1'b0}};
      end
   end

   assign busy = (r_cnt != {LAT_W{1'b0}});

endmodule

// File: rtl/mips_scoreboard.sv
// Register-hazard scoreboard for the issue stage: RAW/WAW stall on registers with pending results.
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module mips_scoreboard
   import mips_pkg::*;
#(
   parameter int LAT_W   = DEF_LAT_W,
   parameter int STATS_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               issue_valid,
   input  logic [4:0]         issue_rs,
   input  logic [4:0]         issue_rt,
   input  logic               issue_uses_rt,
   input  logic               issue_wr_en,
   input  logic [4:0]         issue_wr_addr,
   input  logic [LAT_W-1:0]   issue_lat,
   output logic               stall,
   output logic [31:0]        busy_mask
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [STATS_W-1:0] stall_count
`endif
);

   logic [NUM_REGS-1:0] w_busy;
   logic [NUM_REGS-1:0] w_load;
   logic                w_stall;
   logic                w_accept;

   if (STATS_W < 1) begin : g_bad_stats_w
      $error("mips_scoreboard: STATS_W must be at least 1");
   end

   // r0 is hardwired, so it never holds a reservation and never stalls.
   assign w_busy[REG_ZERO] = 1'b0;
   assign w_load[REG_ZERO] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      localparam reg_addr_t ADDR = reg_addr_t'(i);

      assign w_load[i] = w_accept & issue_wr_en & (issue_wr_addr == ADDR) &
                         (issue_lat != {LAT_W{1'b0}});

      sb_reg_counter #(
         .LAT_W    (LAT_W)
      ) u_cnt (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .load     (w_load[i]),
         .load_val (issue_lat),
         .busy     (w_busy[i])
      );
   end

   // Hazard check: RAW on rs/rt, WAW on the destination.
   always_comb begin
      w_stall = 1'b0;
      if (issue_valid) begin
         w_stall = w_busy[issue_rs] |
                   (issue_uses_rt & w_busy[issue_rt]) |
                   (issue_wr_en & w_busy[issue_wr_addr]);
      end else begin
         w_stall = 1'b0;
      end
   end

   assign w_accept  = issue_valid & ~w_stall & ~flush;
   assign stall     = w_stall;
   assign busy_mask = w_busy;

`ifdef SCOREBOARD_STATS_EN
   logic [STATS_W-1:0] r_stall_count;

   // Saturating count of stalled, non-flushed cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= {STATS_W{1'b0}};
      end else if (w_stall & ~flush & (r_stall_count != {STATS_W{1'b1}})) begin
         r_stall_count <= r_stall_count + {{(STATS_W-1){1'b0}}, 1'b1};
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_mips_scoreboard.sv
// Scoreboard bench for mips_scoreboard: directed hazard cases, then random traffic vs a reference model.
module tb_mips_scoreboard;
   import mips_pkg::*;

   localparam int LAT_W   = 2;
   localparam int STATS_W = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             issue_valid = 1'b0;
   logic [4:0]       issue_rs = 5'd0;
   logic [4:0]       issue_rt = 5'd0;
   logic             issue_uses_rt = 1'b0;
   logic             issue_wr_en = 1'b0;
   logic [4:0]       issue_wr_addr = 5'd0;
   logic [LAT_W-1:0] issue_lat = 2'd0;
   logic             stall;
   logic [31:0]      busy_mask;
`ifdef SCOREBOARD_STATS_EN
   logic [STATS_W-1:0] stall_count;
`endif

   mips_scoreboard #(.LAT_W(LAT_W), .STATS_W(STATS_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .issue_valid   (issue_valid),
      .issue_rs      (issue_rs),
      .issue_rt      (issue_rt),
      .issue_uses_rt (issue_uses_rt),
      .issue_wr_en   (issue_wr_en),
      .issue_wr_addr (issue_wr_addr),
      .issue_lat     (issue_lat),
      .stall         (stall),
      .busy_mask     (busy_mask)
`ifdef SCOREBOARD_STATS_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic [31:0] mask;
      logic [31:0] scnt;
      int          tag;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          mcnt[32];
   logic [31:0] mstat = 32'd0;

   function automatic logic mbusy(input int r);
      return (r != 0) && (mcnt[r] != 0);
   endfunction

   function automatic logic [31:0] mmask();
      logic [31:0] m = 32'd0;
      for (int r = 0; r < 32; r++) m[r] = mbusy(r);
      return m;
   endfunction

   task automatic push_exp(input logic s, input int tag);
      exp_t e;
      e.stall = s;
      e.mask  = mmask();
      e.scnt  = mstat;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // One issue cycle: drive, predict, advance the model across the edge.
   task automatic cyc(input logic v, input int rs, input int rt, input logic urt,
                      input logic wen, input int wa, input int lat, input logic fl, input int tag);
      logic es;
      logic acc;
      issue_valid   = v;
      issue_rs      = 5'(rs);
      issue_rt      = 5'(rt);
      issue_uses_rt = urt;
      issue_wr_en   = wen;
      issue_wr_addr = 5'(wa);
      issue_lat     = 2'(lat);
      flush         = fl;
      es = v && (mbusy(rs) || (urt && mbusy(rt)) || (wen && mbusy(wa)));
      push_exp(es, tag);
      @(posedge clk);
      acc = v && !es && !fl;
      for (int r = 1; r < 32; r++) begin
         if (fl) mcnt[r] = 0;
         else if (acc && wen && wa == r && lat != 0) mcnt[r] = lat;
         else if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      end
      if (es && !fl && mstat != 32'hFFFF_FFFF) mstat = mstat + 32'd1;
      #1;
   endtask

   // Reset asserted mid-cycle: state must read back cleared before any edge.
   task automatic do_reset(input int tag);
      rst_n         = 1'b0;
      issue_valid   = 1'b1;
      issue_rs      = 5'd3;
      issue_rt      = 5'd4;
      issue_uses_rt = 1'b1;
      issue_wr_en   = 1'b1;
      issue_wr_addr = 5'd3;
      issue_lat     = 2'd1;
      flush         = 1'b0;
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      mstat = 32'd0;
      push_exp(1'b0, tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compare each queued expectation at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if (stall !== e.stall) begin
            bad++;
            $display("FAIL stall tag=%0d actual=%b required=%b", e.tag, stall, e.stall);
         end
         total++;
         if (busy_mask !== e.mask) begin
            bad++;
            $display("FAIL busy_mask tag=%0d actual=%h required=%h", e.tag, busy_mask, e.mask);
         end
`ifdef SCOREBOARD_STATS_EN
         total++;
         if (stall_count !== e.scnt) begin
            bad++;
            $display("FAIL stall_count tag=%0d actual=%0d required=%0d", e.tag, stall_count, e.scnt);
         end
`endif
      end
   end

   initial begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      @(posedge clk);
      #1;
      do_reset(1);
      cyc(1'b1, 3, 4, 1'b1, 1'b0, 0, 0, 1'b0, 1);
      // RAW window on r8
      cyc(1'b1, 1, 2, 1'b0, 1'b1, 8, 2, 1'b0, 2);
      repeat (3) cyc(1'b1, 8, 0, 1'b0, 1'b0, 0, 0, 1'b0, 2);
      // r0 never reserves
      cyc(1'b1, 0, 0, 1'b1, 1'b1, 0, 3, 1'b0, 3);
      cyc(1'b1, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 3);
      // WAW on r5 retried until free
      cyc(1'b1, 1, 1, 1'b0, 1'b1, 5, 3, 1'b0, 4);
      repeat (4) cyc(1'b1, 0, 0, 1'b0, 1'b1, 5, 1, 1'b0, 4);
      repeat (2) cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 4);
      // flush beats a same-cycle reservation of r10
      cyc(1'b1, 0, 0, 1'b0, 1'b1, 9, 3, 1'b0, 5);
      cyc(1'b1, 0, 0, 1'b0, 1'b1, 10, 3, 1'b1, 5);
      repeat (2) cyc(1'b1, 10, 9, 1'b1, 1'b0, 0, 0, 1'b0, 5);
      // stall run, then reset in the middle of it
      cyc(1'b1, 0, 0, 1'b0, 1'b1, 11, 3, 1'b0, 6);
      repeat (2) cyc(1'b1, 11, 0, 1'b0, 1'b0, 0, 0, 1'b0, 6);
      cyc(1'b1, 0, 0, 1'b0, 1'b1, 12, 3, 1'b0, 6);
      cyc(1'b1, 12, 0, 1'b0, 1'b0, 0, 0, 1'b0, 6);
      do_reset(6);
      cyc(1'b1, 12, 11, 1'b1, 1'b1, 12, 0, 1'b0, 6);
      // random traffic on a narrow register set to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 39) == 0, 7);
         if (n == 1500) do_reset(8);
      end
      issue_valid = 1'b0;
      flush       = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
